memory_port_arbiter: RTL

- Shares the single SRAM-like memory bus between the IF stage (instruction fetch, read-only) and the IO stage (data load/store).
- Selects one requester per address phase and holds that grant until the bus accepts the address.
- Records the owner of every accepted transaction in an in-order owner FIFO, and routes each returning response to the requester that issued it.
- Sits between the pipeline stages and the external memory interface of the CPU top.

---
 rtl/memory_port_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one in-order memory bus between instruction fetch and data access
// Ports: clock/reset (async, active-high); inst_* fetch port; data_* load/store port;
// bus_* external memory bus; outstanding_count owner FIFO occupancy; protocol_error sticky orphan response flag.
module memory_port_arbiter #(
  parameter int OUTSTANDING_DEPTH = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 inst_request,
  input  logic [DATA_WIDTH-1:0]                inst_address,
  output logic                                 inst_address_ok,
  output logic                                 inst_data_ok,
  output logic [DATA_WIDTH-1:0]                inst_read_data,
  input  logic                                 data_request,
  input  logic                                 data_write,
  input  logic [1:0]                           data_size,
  input  logic [DATA_WIDTH-1:0]                data_address,
  input  logic [DATA_WIDTH-1:0]                data_write_data,
  output logic                                 data_address_ok,
  output logic                                 data_data_ok,
  output logic [DATA_WIDTH-1:0]                data_read_data,
  output logic                                 bus_request,
  output logic                                 bus_write,
  output logic [1:0]                           bus_size,
  output logic [DATA_WIDTH-1:0]                bus_address,
  output logic [DATA_WIDTH-1:0]                bus_write_data,
  input  logic                                 bus_address_ok,
  input  logic                                 bus_data_ok,
  input  logic [DATA_WIDTH-1:0]                bus_read_data,
  output logic [$clog2(OUTSTANDING_DEPTH):0]   outstanding_count,
  output logic                                 protocol_error
);
  localparam int PW = OUTSTANDING_DEPTH > 1 ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int CW = $clog2(OUTSTANDING_DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(OUTSTANDING_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(OUTSTANDING_DEPTH);
  logic [OUTSTANDING_DEPTH-1:0] owner_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic locked, lock_owner, sel_data, full, accept, pop, head;
  // A stalled address phase pins the grant so the bus never sees the address change mid-handshake.
  assign sel_data = locked ? lock_owner : data_request;
  // Full uses the registered count, so a same-cycle pop cannot open a grant.
  assign full = outstanding_count == FULL;
  assign bus_request = !reset && !full && (sel_data ? data_request : inst_request);
  assign bus_write = sel_data && data_write;
  assign bus_size = sel_data ? data_size : 2'd2;
  assign bus_address = sel_data ? data_address : inst_address;
  assign bus_write_data = sel_data ? data_write_data : '0;
  assign accept = bus_request && bus_address_ok;
  assign inst_address_ok = accept && !sel_data;
  assign data_address_ok = accept && sel_data;
  assign head = owner_q[rd_ptr];
  assign pop = bus_data_ok && outstanding_count != '0;
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_read_data = bus_read_data;
  assign data_read_data = bus_read_data;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      locked <= 1'b0;
      lock_owner <= 1'b0;
      outstanding_count <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (bus_request) begin
        locked <= !bus_address_ok;
        lock_owner <= sel_data;
      end
      if (accept) begin
        owner_q[wr_ptr] <= sel_data;
        wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      outstanding_count <= outstanding_count + CW'(accept) - CW'(pop);
      if (bus_data_ok && outstanding_count == '0) protocol_error <= 1'b1;
    end
  end
endmodule
